// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared opcodes, FSM states and control-field encodings for multicycle_control
package rv_ctrl_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EX_R, S_EX_I, S_WB_ALU, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JAL, S_TRAP
  } state_t;
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_CMP    = 2'b01;
  localparam logic [1:0] ALUOP_R      = 2'b10;
  localparam logic [1:0] ALUOP_I      = 2'b11;
  localparam logic [1:0] ALUSRC_B_RS2 = 2'b00;
  localparam logic [1:0] ALUSRC_B_4   = 2'b01;
  localparam logic [1:0] ALUSRC_B_IMM = 2'b10;
  localparam logic [1:0] PC_SRC_PC4   = 2'b00;
  localparam logic [1:0] PC_SRC_TGT   = 2'b01;
  localparam logic [1:0] PC_SRC_TRAP  = 2'b10;
  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MEM = 2'b01;
  localparam logic [1:0] MEMTOREG_PC4 = 2'b10;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: saturating memory wait-state counter with timeout flag
// Ports: clk, rst_n (async active-low), clr (zero the count), en (count this cycle),
//        expire (this waiting cycle is the last one allowed before a timeout)
module mem_wait_timer #(
  parameter int W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam logic [W-1:0] MAX = '1;
  logic [W-1:0] count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else if (clr) count <= '0;
    else if (en && count != MAX) count <= count + 1'b1;
  end
  // The count holds waits already completed, so MAX-1 means this cycle is the MAX-th wait.
  assign expire = en && count >= MAX - 1'b1;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing one RV32I instruction with memory handshake and traps
// Ports: clk, rst_n (async active-low), opcode (IR[6:0]), branch_cond, mem_ready;
//        memory port mem_req/memread/memwrite/iord; datapath controls ir_write, pc_write,
//        pc_src, alusrc_a, alusrc_b, aluop, regwrite, memtoreg; status trap, busy
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter int TIMEOUT_W = 4,
  parameter bit HAS_JAL   = 1,
  parameter int ALUOP_W   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         opcode,
  input  logic               branch_cond,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               memread,
  output logic               memwrite,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               alusrc_a,
  output logic [1:0]         alusrc_b,
  output logic [ALUOP_W-1:0] aluop,
  output logic               regwrite,
  output logic [1:0]         memtoreg,
  output logic               trap,
  output logic               busy
);
  state_t state, state_nx;
  logic expire;
  mem_wait_timer #(.W(TIMEOUT_W)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .clr(mem_ready || state_nx != state),
    .en(state inside {S_FETCH, S_MEM_RD, S_MEM_WR}),
    .expire(expire)
  );
  always_comb begin
    state_nx = S_FETCH;
    case (state)
      S_FETCH:    state_nx = mem_ready ? S_DECODE : expire ? S_TRAP : S_FETCH;
      S_DECODE:   state_nx = opcode == OP_R ? S_EX_R :
                             opcode == OP_IMM ? S_EX_I :
                             (opcode == OP_LOAD || opcode == OP_STORE) ? S_MEM_ADDR :
                             opcode == OP_BRANCH ? S_BRANCH :
                             (HAS_JAL && opcode == OP_JAL) ? S_JAL : S_TRAP;
      S_EX_R:     state_nx = S_WB_ALU;
      S_EX_I:     state_nx = S_WB_ALU;
      S_MEM_ADDR: state_nx = opcode == OP_STORE ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_nx = mem_ready ? S_MEM_WB : expire ? S_TRAP : S_MEM_RD;
      S_MEM_WR:   state_nx = mem_ready ? S_FETCH : expire ? S_TRAP : S_MEM_WR;
      default:    state_nx = S_FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  end
  always_comb begin
    mem_req  = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    iord     = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src   = PC_SRC_PC4;
    alusrc_a = 1'b0;
    alusrc_b = ALUSRC_B_RS2;
    aluop    = ALUOP_W'(ALUOP_ADD);
    regwrite = 1'b0;
    memtoreg = MEMTOREG_ALU;
    trap     = 1'b0;
    busy     = state != S_IDLE;
    case (state)
      S_FETCH: begin
        mem_req  = 1'b1;
        memread  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
        alusrc_b = mem_ready ? ALUSRC_B_4 : ALUSRC_B_RS2;
      end
      S_DECODE: alusrc_b = ALUSRC_B_IMM;
      S_EX_R: begin
        alusrc_a = 1'b1;
        aluop    = ALUOP_W'(ALUOP_R);
      end
      S_EX_I: begin
        alusrc_a = 1'b1;
        alusrc_b = ALUSRC_B_IMM;
        aluop    = ALUOP_W'(ALUOP_I);
      end
      S_WB_ALU: regwrite = 1'b1;
      S_MEM_ADDR: begin
        alusrc_a = 1'b1;
        alusrc_b = ALUSRC_B_IMM;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEM_WB: begin
        regwrite = 1'b1;
        memtoreg = MEMTOREG_MEM;
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_BRANCH: begin
        alusrc_a = 1'b1;
        aluop    = ALUOP_W'(ALUOP_CMP);
        pc_src   = PC_SRC_TGT;
        pc_write = branch_cond;
      end
      S_JAL: begin
        pc_write = 1'b1;
        pc_src   = PC_SRC_TGT;
        regwrite = 1'b1;
        memtoreg = MEMTOREG_PC4;
      end
      S_TRAP: begin
        trap     = 1'b1;
        pc_write = 1'b1;
        pc_src   = PC_SRC_TRAP;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed table, random instruction stream and reset corner cases
module tb_multicycle_control;
  import rv_ctrl_pkg::*;
  // Control word layout: req rd wr iord | irw pcw | pc_src | asa | asb | aluop | rw | m2r | trap busy
  localparam logic [17:0] FW  = 18'b1100_00_00_0_00_00_0_00_01;
  localparam logic [17:0] FG  = 18'b1100_11_00_0_01_00_0_00_01;
  localparam logic [17:0] DEC = 18'b0000_00_00_0_10_00_0_00_01;
  localparam logic [17:0] EXR = 18'b0000_00_00_1_00_10_0_00_01;
  localparam logic [17:0] EXI = 18'b0000_00_00_1_10_11_0_00_01;
  localparam logic [17:0] WBA = 18'b0000_00_00_0_00_00_1_00_01;
  localparam logic [17:0] MAD = 18'b0000_00_00_1_10_00_0_00_01;
  localparam logic [17:0] MRD = 18'b1101_00_00_0_00_00_0_00_01;
  localparam logic [17:0] MWB = 18'b0000_00_00_0_00_00_1_01_01;
  localparam logic [17:0] MWR = 18'b1011_00_00_0_00_00_0_00_01;
  localparam logic [17:0] BR1 = 18'b0000_01_01_1_00_01_0_00_01;
  localparam logic [17:0] BR0 = 18'b0000_00_01_1_00_01_0_00_01;
  localparam logic [17:0] JAL = 18'b0000_01_01_0_00_00_1_10_01;
  localparam logic [17:0] TRP = 18'b0000_01_10_0_00_00_0_00_11;
  localparam logic [17:0] IDL = 18'b0;
  typedef struct {bit rdy; logic [17:0] exp;} step_t;
  typedef struct {logic [6:0] op; int fw; int mw; bit bc; int rw; int tr0; int tr1;} vec_t;
  logic clk = 1'b0, rst_n = 1'b0, branch_cond = 1'b0, mem_ready = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic r0, rd0, wr0, io0, irw0, pcw0, asa0, rw0, tr0, b0;
  logic r1, rd1, wr1, io1, irw1, pcw1, asa1, rw1, tr1, b1;
  logic [1:0] pcs0, asb0, aop0, m2r0, pcs1, asb1, aop1, m2r1;
  logic [17:0] g0, g1;
  int passed = 0, total = 0;
  step_t q0[$], q1[$];
  assign g0 = {r0, rd0, wr0, io0, irw0, pcw0, pcs0, asa0, asb0, aop0, rw0, m2r0, tr0, b0};
  assign g1 = {r1, rd1, wr1, io1, irw1, pcw1, pcs1, asa1, asb1, aop1, rw1, m2r1, tr1, b1};
  always #5 clk = ~clk;
  multicycle_control u0 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_cond(branch_cond), .mem_ready(mem_ready),
    .mem_req(r0), .memread(rd0), .memwrite(wr0), .iord(io0), .ir_write(irw0), .pc_write(pcw0),
    .pc_src(pcs0), .alusrc_a(asa0), .alusrc_b(asb0), .aluop(aop0), .regwrite(rw0),
    .memtoreg(m2r0), .trap(tr0), .busy(b0)
  );
  multicycle_control #(.HAS_JAL(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_cond(branch_cond), .mem_ready(mem_ready),
    .mem_req(r1), .memread(rd1), .memwrite(wr1), .iord(io1), .ir_write(irw1), .pc_write(pcw1),
    .pc_src(pcs1), .alusrc_a(asa1), .alusrc_b(asb1), .aluop(aop1), .regwrite(rw1),
    .memtoreg(m2r1), .trap(tr1), .busy(b1)
  );
  task automatic chk(string nm, int idx, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s #%0d got=%h exp=%h", nm, idx, got, exp);
  endtask
  task automatic push(bit w1, bit rdy, logic [17:0] e);
    step_t s;
    s.rdy = rdy;
    s.exp = e;
    if (w1) q1.push_back(s);
    else q0.push_back(s);
  endtask
  // Expected per-cycle control words for one instruction, built from the instruction class.
  task automatic plan(bit w1, logic [6:0] op, int fw, int mw, bit bc, bit hj);
    bit st = op == OP_STORE;
    for (int k = 0; k < (fw > 15 ? 15 : fw); k++) push(w1, 1'b0, FW);
    if (fw >= 15) begin
      push(w1, 1'($urandom), TRP);
      return;
    end
    push(w1, 1'b1, FG);
    push(w1, 1'($urandom), DEC);
    if (op == OP_R) begin
      push(w1, 1'($urandom), EXR);
      push(w1, 1'($urandom), WBA);
    end else if (op == OP_IMM) begin
      push(w1, 1'($urandom), EXI);
      push(w1, 1'($urandom), WBA);
    end else if (op == OP_LOAD || op == OP_STORE) begin
      push(w1, 1'($urandom), MAD);
      for (int k = 0; k < (mw > 15 ? 15 : mw); k++) push(w1, 1'b0, st ? MWR : MRD);
      if (mw >= 15) push(w1, 1'($urandom), TRP);
      else begin
        push(w1, 1'b1, st ? MWR : MRD);
        if (!st) push(w1, 1'($urandom), MWB);
      end
    end else if (op == OP_BRANCH) push(w1, 1'($urandom), bc ? BR1 : BR0);
    else if (op == OP_JAL && hj) push(w1, 1'($urandom), JAL);
    else push(w1, 1'($urandom), TRP);
  endtask
  task automatic run(int id, logic [6:0] op, int fw, int mw, bit bc,
                     output int rw, output int t0, output int t1);
    int fl = fw >= 15 ? 16 : fw + 1;
    q0.delete();
    q1.delete();
    plan(1'b0, op, fw, mw, bc, 1'b1);
    plan(1'b1, op, fw, mw, bc, 1'b0);
    rw = 0;
    t0 = 0;
    t1 = 0;
    foreach (q0[i]) begin
      @(negedge clk);
      opcode = i < fl ? 7'($urandom) : op;
      mem_ready = q0[i].rdy;
      branch_cond = i < fl ? 1'($urandom) : bc;
      #1;
      chk("seq_jal1", id * 100 + i, g0, q0[i].exp);
      chk("seq_jal0", id * 100 + i, g1, q1[i].exp);
      rw += int'(g0[4]);
      t0 += int'(g0[1]);
      t1 += int'(g1[1]);
    end
  endtask
  initial begin
    vec_t tbl[13];
    logic [6:0] ops[6];
    int rw, t0, t1;
    tbl[0]  = '{OP_R,      0,  0, 1'b0, 1, 0, 0};
    tbl[1]  = '{OP_IMM,    2,  0, 1'b0, 1, 0, 0};
    tbl[2]  = '{OP_LOAD,   0,  3, 1'b0, 1, 0, 0};
    tbl[3]  = '{OP_STORE,  1,  0, 1'b0, 0, 0, 0};
    tbl[4]  = '{OP_BRANCH, 0,  0, 1'b1, 0, 0, 0};
    tbl[5]  = '{OP_BRANCH, 0,  0, 1'b0, 0, 0, 0};
    tbl[6]  = '{OP_JAL,    0,  0, 1'b0, 1, 0, 1};
    tbl[7]  = '{7'h7F,     0,  0, 1'b0, 0, 1, 1};
    tbl[8]  = '{OP_STORE,  0, 15, 1'b0, 0, 1, 1};
    tbl[9]  = '{OP_STORE,  0, 14, 1'b0, 0, 0, 0};
    tbl[10] = '{OP_R,     15,  0, 1'b0, 0, 1, 1};
    tbl[11] = '{OP_LOAD,   0, 14, 1'b0, 1, 0, 0};
    tbl[12] = '{OP_LOAD,   0, 20, 1'b0, 0, 1, 1};
    ops = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL};
    @(negedge clk);
    #1;
    chk("reset_u0", 0, g0, IDL);
    chk("reset_u1", 0, g1, IDL);
    rst_n = 1'b1;
    #1;
    chk("idle_after_release", 0, g0, IDL);
    foreach (tbl[i]) begin
      run(i, tbl[i].op, tbl[i].fw, tbl[i].mw, tbl[i].bc, rw, t0, t1);
      chk("regwrite_cycles", i, rw, tbl[i].rw);
      chk("trap_pulses_jal1", i, t0, tbl[i].tr0);
      chk("trap_pulses_jal0", i, t1, tbl[i].tr1);
    end
    for (int n = 0; n < 80; n++) begin
      int sel = $urandom_range(0, 6);
      logic [6:0] op = sel == 6 ? 7'($urandom) : ops[sel];
      int fw = $urandom_range(0, 9) == 0 ? $urandom_range(13, 16) : $urandom_range(0, 3);
      int mw = $urandom_range(0, 9) == 0 ? $urandom_range(13, 16) : $urandom_range(0, 3);
      run(100 + n, op, fw, mw, 1'($urandom), rw, t0, t1);
    end
    @(negedge clk);
    opcode = OP_STORE;
    mem_ready = 1'b1;
    #1;
    chk("rst_fetch", 0, g0, FG);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("rst_decode", 0, g0, DEC);
    @(negedge clk);
    #1;
    chk("rst_memaddr", 0, g0, MAD);
    @(negedge clk);
    #1;
    chk("rst_memwr", 0, g0, MWR);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_drop", 0, g0, IDL);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("one_idle_cycle", 0, g0, IDL);
    @(negedge clk);
    #1;
    chk("fetch_after_reset", 0, g0, FW);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Successor to the single-cycle combinational opcode decoder. This is a Moore FSM that sequences one RV32I instruction over several cycles.
- Supported instructions: R-type, I-ALU, load, store, branch and JAL.
- Adds a request/ready handshake to a shared instruction/data memory, a wait-state timeout, and an illegal-opcode trap.
- Sits between the instruction register and the datapath muxes, ALU control, register file and memory port.

Parameters:
- TIMEOUT_W, 4: width of the memory wait counter. A trap fires after 2^TIMEOUT_W-1 cycles without mem_ready.
- HAS_JAL, 1: 1 = JAL (1101111) is decoded; 0 = JAL opcode is treated as illegal.
- ALUOP_W, 2: width of the aluop output.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instr[6:0] from the instruction register
- branch_cond  in  1  ALU comparator result for the branch currently in EXEC
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request valid
- memread  out  1  request is a read
- memwrite  out  1  request is a write
- iord  out  1  0 = address from PC, 1 = address from ALU result
- ir_write  out  1  load the instruction register
- pc_write  out  1  update the PC
- pc_src  out  2  00 = PC+4, 01 = branch/JAL target, 10 = trap vector
- alusrc_a  out  1  0 = PC, 1 = rs1
- alusrc_b  out  2  00 = rs2, 01 = constant 4, 10 = immediate
- aluop  out  ALUOP_W  00 = add, 01 = compare, 10 = R funct, 11 = I funct
- regwrite  out  1  register file write enable
- memtoreg  out  2  00 = ALU result, 01 = memory data, 10 = PC+4
- trap  out  1  one-cycle pulse on illegal opcode or memory timeout
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: async on rst_n low. State goes to IDLE, wait counter to 0, all outputs to 0.
- IDLE always advances to FETCH on the next clock, so reset release gives exactly one idle cycle.
- Outputs are decoded only from the registered state, plus mem_ready/branch_cond where noted. No output is affected by opcode outside DECODE.
- FETCH:
  - Drives mem_req=1, memread=1, iord=0.
  - Holds until mem_ready. On the mem_ready cycle it also drives ir_write=1, pc_write=1, pc_src=00, alusrc_a=0, alusrc_b=01, aluop=00, then goes to DECODE.
- DECODE: alusrc_a=0, alusrc_b=10, aluop=00 (precomputes branch/JAL target). Next state by opcode:
  - 0110011 -> EX_R
  - 0010011 -> EX_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL, if HAS_JAL=1
  - anything else -> TRAP
- EX_R: alusrc_a=1, alusrc_b=00, aluop=10. Goes to WB_ALU.
- EX_I: alusrc_a=1, alusrc_b=10, aluop=11. Goes to WB_ALU.
- WB_ALU: regwrite=1, memtoreg=00. Goes to FETCH.
- MEM_ADDR: alusrc_a=1, alusrc_b=10, aluop=00. Goes to MEM_RD for a load or MEM_WR for a store, using the opcode latched in the IR.
- MEM_RD: mem_req=1, memread=1, iord=1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB: regwrite=1, memtoreg=01. Goes to FETCH.
- MEM_WR: mem_req=1, memwrite=1, iord=1. Holds until mem_ready, then goes to FETCH.
- BRANCH: alusrc_a=1, alusrc_b=00, aluop=01, pc_src=01, pc_write=branch_cond. Goes to FETCH.
- JAL: pc_write=1, pc_src=01, regwrite=1, memtoreg=10. Goes to FETCH.
- TRAP: trap=1, pc_write=1, pc_src=10 for exactly one cycle, then goes to FETCH.
- Handshake rules:
  - mem_req, memread/memwrite and iord stay stable from the first request cycle through the mem_ready cycle.
  - mem_ready seen outside FETCH/MEM_RD/MEM_WR is ignored.
  - mem_ready on the first request cycle gives a zero-wait transfer.
- Wait counter:
  - Counts cycles spent in a request state without mem_ready.
  - Clears on mem_ready and on every state change.
  - When it reaches all-ones (2^TIMEOUT_W-1) with mem_ready still low, next state is TRAP and the request drops.
  - The counter saturates and never wraps.
  - mem_ready on the same cycle as the count reaching all-ones wins: the transfer completes and there is no trap.
- memread and memwrite are never both 1.
- An illegal opcode never asserts regwrite, memwrite or mem_req.
- Reset asserted mid-request drops mem_req asynchronously.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL);
  - the state enum;
  - ALUOP, ALUSRC_B, PC_SRC and MEMTOREG encodings.
- One natural sub-module, mem_wait_timer: a saturating counter plus timeout flag with clear and enable inputs.

Test Plan:
- R-type 0110011 with mem_ready tied high -> states FETCH, DECODE, EX_R, WB_ALU; regwrite=1 for exactly 1 cycle; 4 cycles per instruction.
- Load 0000011 with mem_ready delayed 3 cycles in MEM_RD -> mem_req, memread and iord=1 stable for 4 cycles; then MEM_WB with memtoreg=01 and regwrite=1; 8 cycles total.
- Branch 1100011 with branch_cond=1 and then branch_cond=0 -> pc_write=1 with pc_src=01 in the first case; pc_write=0 in the second; both return to FETCH.
- Opcode 1111111, and JAL with HAS_JAL=0 -> DECODE then TRAP; single trap pulse; pc_src=10; no regwrite, memwrite or mem_req.
- Store with mem_ready never asserted and TIMEOUT_W=4 -> trap after 15 request cycles in MEM_WR. Repeat with mem_ready on exactly the 15th cycle -> no trap, returns to FETCH.
- rst_n pulled low mid-MEM_WR -> mem_req=0 immediately; after release one IDLE cycle, then FETCH with mem_req=1 and iord=0.
